// File: rtl/prmcu_uart_arb.sv
// Round-robin arbiter sharing the UART transmit stream between N_REQ message producers.
// Latency: grant registered one edge after a request is seen in IDLE; data path req->out is combinational.
// Backpressure: out_rdy_i is routed only to the granted requester; others see ready low until granted.
// Optional build macro PRMCU_UART_ARB_PRIO_EN: requester 0 wins every IDLE scan and does not advance ptr.
module prmcu_uart_arb #(
    parameter int N_REQ     = 4,
    parameter int DAT_W     = 9,
    parameter int MAX_BURST = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arb_en,
    input  logic [N_REQ*DAT_W-1:0] req_dat_i,
    input  logic [N_REQ-1:0]       req_vld_i,
    input  logic [N_REQ-1:0]       req_last_i,
    output logic [N_REQ-1:0]       req_rdy_o,
    output logic [DAT_W-1:0]       out_dat_o,
    output logic                   out_vld_o,
    input  logic                   out_rdy_i,
    output logic [N_REQ-1:0]       grant_o,
    output logic                   busy_o
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_nxt;
    logic [PW-1:0]     gidx;
    logic [PW-1:0]     gidx_nxt;
    logic [CW-1:0]     beat_cnt;
    logic [CW-1:0]     beat_cnt_nxt;
    logic [N_REQ-1:0]  grant;
    logic [N_REQ-1:0]  grant_nxt;
    logic [PW-1:0]     pick;
    logic [DAT_W-1:0]  mux_dat;
    logic              accept;
    logic              last_g;
    logic              msg_end;

    // Round-robin scan: first valid requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin : rr_scan
        logic [PW-1:0] cand;
        logic          found;
        pick  = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(ptr) + i >= N_REQ) begin
                cand = PW'(int'(ptr) + i - N_REQ);
            end else begin
                cand = PW'(int'(ptr) + i);
            end
            if (!found && req_vld_i[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
`ifdef PRMCU_UART_ARB_PRIO_EN
        // Requester 0 overrides the rotating scan whenever it is asking.
        if (req_vld_i[0]) begin
            pick = '0;
        end
`endif
    end

    // One-hot AND-OR data mux; grant is all zeros in IDLE so the output data is zero there.
    always_comb begin
        mux_dat = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                mux_dat = mux_dat | req_dat_i[k*DAT_W +: DAT_W];
            end
        end
    end

    assign out_dat_o = mux_dat;
    assign out_vld_o = |(grant & req_vld_i);
    assign req_rdy_o = grant & {N_REQ{out_rdy_i}};
    assign grant_o   = grant;
    assign busy_o    = (state == S_GRANT);
    assign accept    = out_vld_o & out_rdy_i;
    assign last_g    = |(grant & req_last_i);
    assign msg_end   = last_g || (beat_cnt == CW'(MAX_BURST - 1));

    // State register and per-grant bookkeeping; synchronous reset drops any partial message.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            gidx     <= '0;
            beat_cnt <= '0;
            grant    <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            gidx     <= gidx_nxt;
            beat_cnt <= beat_cnt_nxt;
            grant    <= grant_nxt;
        end
    end

    // Next-state logic: issue a grant from IDLE, hold it until last beat or burst limit.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        gidx_nxt     = gidx;
        beat_cnt_nxt = beat_cnt;
        grant_nxt    = grant;
        case (state)
            S_IDLE: begin
                if (arb_en && (|req_vld_i)) begin
                    state_nxt    = S_GRANT;
                    gidx_nxt     = pick;
                    grant_nxt    = N_REQ'(1) << pick;
                    beat_cnt_nxt = '0;
                end
            end
            S_GRANT: begin
                // arb_en is ignored here so a started message always completes.
                if (accept) begin
                    if (msg_end) begin
                        state_nxt    = S_IDLE;
                        grant_nxt    = '0;
                        beat_cnt_nxt = '0;
`ifdef PRMCU_UART_ARB_PRIO_EN
                        // Priority grants leave the rotation untouched so 1..N_REQ-1 stay fair.
                        if (gidx != '0) begin
                            ptr_nxt = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
                        end
`else
                        ptr_nxt = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
`endif
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_prmcu_uart_arb.sv
// Self-checking bench for prmcu_uart_arb: vector table, directed message sequences, random traffic.
// A cycle-level reference model (plain integers) predicts every output at each falling edge.
// Accepted beats are logged as (requester, data) and compared with hand-built expected orders.
module tb_prmcu_uart_arb;

    localparam int N  = 4;
    localparam int W  = 9;
    localparam int MB = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           arb_en;
    logic [N*W-1:0] req_dat;
    logic [N-1:0]   req_vld;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_rdy;
    logic [W-1:0]   out_dat;
    logic           out_vld;
    logic           out_rdy;
    logic [N-1:0]   grant;
    logic           busy;

    always #5 clk = ~clk;

    prmcu_uart_arb #(.N_REQ(N), .DAT_W(W), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst        (rst),
        .arb_en     (arb_en),
        .req_dat_i  (req_dat),
        .req_vld_i  (req_vld),
        .req_last_i (req_last),
        .req_rdy_o  (req_rdy),
        .out_dat_o  (out_dat),
        .out_vld_o  (out_vld),
        .out_rdy_i  (out_rdy),
        .grant_o    (grant),
        .busy_o     (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: current grant (-1 = idle), rotation pointer, beats in this grant.
    int m_g   = -1;
    int m_ptr = 0;
    int m_cnt = 0;

    int log_g[$];
    int log_d[$];
    int exp_g[$];
    int exp_d[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_slice(int k, logic [W-1:0] v);
        req_dat[k*W +: W] = v;
    endtask

    function automatic int model_pick();
`ifdef PRMCU_UART_ARB_PRIO_EN
        if (req_vld[0]) return 0;
`endif
        for (int i = 0; i < N; i++) begin
            if (req_vld[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    // Falling edge: compare all outputs with the model, log accepted beats.
    task automatic at_neg();
        logic [N-1:0] e_grant;
        logic [N-1:0] e_rdy;
        logic [W-1:0] e_dat;
        logic         e_vld;
        @(negedge clk);
        e_grant = '0; e_rdy = '0; e_dat = '0; e_vld = 1'b0;
        if (m_g >= 0) begin
            e_grant[m_g] = 1'b1;
            e_vld        = req_vld[m_g];
            e_rdy[m_g]   = out_rdy;
            e_dat        = req_dat[m_g*W +: W];
        end
        check("grant", grant, e_grant);
        check("busy", busy, m_g >= 0);
        check("out_vld", out_vld, e_vld);
        check("out_dat", out_dat, e_dat);
        check("req_rdy", req_rdy, e_rdy);
        if (out_vld && out_rdy) begin
            int gi = -1;
            for (int k = 0; k < N; k++) if (grant[k]) gi = k;
            log_g.push_back(gi);
            log_d.push_back(int'(out_dat));
        end
    endtask

    // Rising edge: advance the model with the inputs the DUT just sampled.
    task automatic adv();
        @(posedge clk);
        if (rst) begin
            m_g = -1; m_ptr = 0; m_cnt = 0;
        end else if (m_g < 0) begin
            if (arb_en && req_vld != '0) begin
                m_g = model_pick(); m_cnt = 0;
            end
        end else if (req_vld[m_g] && out_rdy) begin
            if (req_last[m_g] || m_cnt == MB - 1) begin
`ifdef PRMCU_UART_ARB_PRIO_EN
                if (m_g != 0) m_ptr = (m_g + 1) % N;
`else
                m_ptr = (m_g + 1) % N;
`endif
                m_g = -1; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        #1;
    endtask

    task automatic tick();
        at_neg();
        adv();
    endtask

    task automatic do_reset();
        rst = 1'b1; arb_en = 1'b1; out_rdy = 1'b1;
        req_vld = '0; req_last = '0; req_dat = '0;
        @(posedge clk);
        #1;
        m_g = -1; m_ptr = 0; m_cnt = 0;
        rst = 1'b0;
        log_g.delete(); log_d.delete(); exp_g.delete(); exp_d.delete();
    endtask

    task automatic compare_log(string name);
        check({name, "_count"}, log_g.size() >= exp_g.size(), 1'b1);
        for (int i = 0; i < exp_g.size(); i++) begin
            if (i < log_g.size()) begin
                check({name, "_req"}, log_g[i], exp_g[i]);
                check({name, "_dat"}, log_d[i], exp_d[i]);
            end
        end
    endtask

    typedef struct {
        logic [N-1:0] vld;
        logic [N-1:0] last;
        logic         rdy;
        logic         en;
        logic [N-1:0] e_grant;
        logic         e_vld;
        logic [N-1:0] e_rdy;
        logic [W-1:0] e_dat;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int n1, n0, n2;

        // Cycle-by-cycle vectors from reset (ptr = 0); slice k carries 0x0A0+k.
        tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 9'h000};
        tbl[1]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 9'h000};
        tbl[2]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 1'b1, 4'b0100, 9'h0A2};
        tbl[3]  = '{4'b0100, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0000, 9'h0A2};
        tbl[4]  = '{4'b0100, 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 4'b0100, 9'h0A2};
        tbl[5]  = '{4'b1001, 4'b1001, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 9'h000};
        tbl[6]  = '{4'b1001, 4'b1001, 1'b1, 1'b1, 4'b1000, 1'b1, 4'b1000, 9'h0A3};
        tbl[7]  = '{4'b1001, 4'b1001, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 9'h000};
        tbl[8]  = '{4'b1001, 4'b1001, 1'b1, 1'b1, 4'b0001, 1'b1, 4'b0001, 9'h0A0};
        tbl[9]  = '{4'b1001, 4'b1001, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 9'h000};
        tbl[10] = '{4'b1001, 4'b1001, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 9'h000};
        tbl[11] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 9'h000};

        do_reset();
        for (int k = 0; k < N; k++) set_slice(k, W'(9'h0A0 + k));
        for (int i = 0; i < 12; i++) begin
            req_vld = tbl[i].vld; req_last = tbl[i].last;
            out_rdy = tbl[i].rdy; arb_en = tbl[i].en;
            at_neg();
            check($sformatf("vec%0d_grant", i), grant, tbl[i].e_grant);
            check($sformatf("vec%0d_vld", i), out_vld, tbl[i].e_vld);
            check($sformatf("vec%0d_rdy", i), req_rdy, tbl[i].e_rdy);
            check($sformatf("vec%0d_dat", i), out_dat, tbl[i].e_dat);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].e_grant != 0);
            adv();
        end

        // Reset in the second grant cycle of a 3-beat message from requester 2.
        do_reset();
        req_vld = 4'b0100; set_slice(2, 9'h00A);
        tick();
        tick();
        set_slice(2, 9'h00B);
        rst = 1'b1;
        tick();
        rst = 1'b0; req_vld = '0;
        at_neg();
        check("rst_mid_grant", grant, 4'b0000);
        check("rst_mid_vld", out_vld, 1'b0);
        check("rst_mid_dat", out_dat, 9'h000);
        check("rst_mid_rdy", req_rdy, 4'b0000);
        check("rst_mid_busy", busy, 1'b0);
        adv();
        req_vld = 4'b1111; req_last = 4'b1111;
        tick();
        at_neg();
        check("rst_mid_ptr0", grant, 4'b0001);
        adv();

        // All four requesters streaming single-beat messages.
        do_reset();
        for (int k = 0; k < N; k++) set_slice(k, W'(9'h1C0 + k));
        req_vld = 4'b1111; req_last = 4'b1111;
        for (int c = 0; c < 16; c++) tick();
        check("rr_rate", log_g.size(), 8);
        for (int i = 0; i < 8; i++) begin
`ifdef PRMCU_UART_ARB_PRIO_EN
            exp_g.push_back(0);
            exp_d.push_back(9'h1C0);
`else
            exp_g.push_back(i % N);
            exp_d.push_back(9'h1C0 + i % N);
`endif
        end
        compare_log("rr");

        // Requester 1 five-beat message under toggling backpressure, requester 3 waiting.
        do_reset();
        n1 = 0;
        set_slice(3, 9'h1F3); req_last[3] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            req_vld[1]  = (n1 < 5);
            set_slice(1, W'(9'h101 + n1));
            req_last[1] = (n1 == 4);
            req_vld[3]  = 1'b1;
            out_rdy     = (c % 2 == 0);
            at_neg();
            if (n1 < 5) check("bp_rdy3_low", req_rdy[3], 1'b0);
            if (req_vld[1] && req_rdy[1]) n1++;
            adv();
        end
        check("bp_done", n1, 5);
        for (int i = 0; i < 5; i++) begin
            exp_g.push_back(1); exp_d.push_back(9'h101 + i);
        end
        exp_g.push_back(3); exp_d.push_back(9'h1F3);
        compare_log("bp");

        // Requester 0 streams 20 beats with no last; requester 1 waits with 1-beat messages.
        do_reset();
        n0 = 0; out_rdy = 1'b1;
        set_slice(1, 9'h1AA); req_last = 4'b0010;
        for (int c = 0; c < 60; c++) begin
            req_vld[0] = (n0 < 20);
            set_slice(0, W'(n0 + 1));
            req_vld[1] = 1'b1;
            at_neg();
            if (req_vld[0] && req_rdy[0]) n0++;
            adv();
        end
        check("burst_done", n0, 20);
`ifdef PRMCU_UART_ARB_PRIO_EN
        for (int i = 0; i < 20; i++) begin exp_g.push_back(0); exp_d.push_back(i + 1); end
        exp_g.push_back(1); exp_d.push_back(9'h1AA);
`else
        for (int i = 0; i < 16; i++) begin exp_g.push_back(0); exp_d.push_back(i + 1); end
        exp_g.push_back(1); exp_d.push_back(9'h1AA);
        for (int i = 16; i < 20; i++) begin exp_g.push_back(0); exp_d.push_back(i + 1); end
`endif
        compare_log("burst");

        // arb_en dropped during a 4-beat message from requester 2.
        do_reset();
        n2 = 0;
        set_slice(0, 9'h050); req_last[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            req_vld[2]  = (n2 < 4);
            set_slice(2, W'(9'h0C1 + n2));
            req_last[2] = (n2 == 3);
            req_vld[0]  = (n2 >= 1);
            arb_en      = (n2 < 2);
            at_neg();
            if (n2 == 4) check("en_hold_idle", grant, 4'b0000);
            if (req_vld[2] && req_rdy[2]) n2++;
            adv();
        end
        check("en_msg_done", n2, 4);
        arb_en = 1'b1;
        tick();
        at_neg();
        check("en_regrant", grant, 4'b0001);
        adv();
        for (int i = 0; i < 4; i++) begin exp_g.push_back(2); exp_d.push_back(9'h0C1 + i); end
        compare_log("en");

`ifdef PRMCU_UART_ARB_PRIO_EN
        // Requester 0 keeps winning until it drops valid; then requester 3 gets in.
        do_reset();
        for (int k = 0; k < N; k++) set_slice(k, W'(9'h0D0 + k));
        req_vld = 4'b1001; req_last = 4'b1001;
        for (int c = 0; c < 12; c++) tick();
        req_vld = 4'b1000;
        for (int c = 0; c < 6; c++) tick();
        for (int i = 0; i < 6; i++) begin exp_g.push_back(0); exp_d.push_back(9'h0D0); end
        exp_g.push_back(3); exp_d.push_back(9'h0D3);
        compare_log("prio");
`endif

        // Random traffic, occasional reset, checked against the model every cycle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req_vld  = N'($urandom);
            req_last = N'($urandom);
            out_rdy  = ($urandom_range(0, 3) != 0);
            arb_en   = ($urandom_range(0, 9) != 0);
            rst      = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < N; k++) set_slice(k, W'($urandom));
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prmcu_uart_arb.md
# prmcu_uart_arb

Round-robin arbiter that shares the single transmit input stream of `prmcu_uart_top` (`in_dat_i`/`in_vld_i`/`in_rdy_o`) between `N_REQ` requesters. A grant is held for a whole message, which ends on a `last` beat or at a burst limit, so frames from different requesters never interleave on `tx_o`. It sits between the MCU-side producers and the UART top and uses the same clock.

## Interface

Parameters:
- `N_REQ`, 4, number of requesters (2..8).
- `DAT_W`, 9, beat width; matches the UART `in_dat_i` width.
- `MAX_BURST`, 16, maximum beats per grant (2..256).

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `rst`  in  1  synchronous, active-high reset.
- `arb_en`  in  1  arbitration enable; when low, no new grant is issued.
- `req_dat_i`  in  `N_REQ*DAT_W`  requester data; requester k occupies bits `[k*DAT_W +: DAT_W]`.
- `req_vld_i`  in  `N_REQ`  per-requester valid.
- `req_last_i`  in  `N_REQ`  per-requester end-of-message flag; sampled with valid.
- `req_rdy_o`  out  `N_REQ`  per-requester ready.
- `out_dat_o`  out  `DAT_W`  to UART `in_dat_i`.
- `out_vld_o`  out  1  to UART `in_vld_i`.
- `out_rdy_i`  in  1  from UART `in_rdy_o`.
- `grant_o`  out  `N_REQ`  one-hot current grant; all zeros when idle.
- `busy_o`  out  1  high while in GRANT.

## Operation

- FSM has two states, IDLE and GRANT.
- IDLE:
  - If `arb_en`=1 and any `req_vld_i` bit is set, select the first set bit scanning from `ptr`, wrapping modulo `N_REQ`.
  - Register the selection into `grant_o`, clear `beat_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, with g the granted index:
  - `out_dat_o` = requester g's data slice; `out_vld_o` = `req_vld_i[g]`; `req_rdy_o[g]` = `out_rdy_i`.
  - All other `req_rdy_o` bits = 0.
  - A beat is accepted when `out_vld_o & out_rdy_i`.
  - On each accept, `beat_cnt` increments. `beat_cnt` is `$clog2(MAX_BURST)` bits wide and never wraps, because the grant ends first.
- Grant release happens on an accepted beat with `req_last_i[g]`=1, or on an accepted beat when `beat_cnt` = `MAX_BURST-1`. On release:
  - Go to IDLE.
  - Set `ptr` to (g+1) mod `N_REQ`.
  - Set `grant_o` to 0.
- A granted requester that drops valid mid-message keeps the grant; there is no timeout.
- Requesters must hold data stable while valid is high and ready is low (standard valid/ready rules).
- `arb_en` deasserted during GRANT does not abort the message. The current message completes, then the FSM stays in IDLE.
- In IDLE, `out_vld_o`=0, `req_rdy_o`=0, and `out_dat_o`=0.

## Timing

- Reset values:
  - State = IDLE; `ptr` = 0; `beat_cnt` = 0.
  - `grant_o` = 0; `busy_o` = 0; `out_vld_o` = 0; `out_dat_o` = 0; `req_rdy_o` = 0.
- Reset asserted mid-message forces IDLE on the next edge. The partial message is dropped by the arbiter; UART-side recovery is the upstream producer's job.
- Latency: a request seen in IDLE at edge n gives `grant_o` and `out_vld_o` valid after edge n. The first beat can be accepted in cycle n+1.
- There is exactly one IDLE bubble cycle between consecutive grants. Sustained throughput is therefore `MAX_BURST`/(`MAX_BURST`+1) beats per cycle. The UART is far slower, so this is acceptable.
- Data path from `req_*` to `out_*` is combinational through the one-hot grant mux. There is no extra register stage.
- Simultaneous requests are resolved by a single RR scan from `ptr`. A requester asserting valid on the same cycle another message is released waits for the IDLE scan.
- `req_last_i[g]` with valid but not ready has no effect until the beat is accepted.

## Configuration

- `PRMCU_UART_ARB_PRIO_EN` defined:
  - Requester 0 has strict priority in IDLE: if `req_vld_i[0]`=1, it is granted regardless of `ptr`.
  - Other requesters use RR as above.
  - When requester 0's grant is released, `ptr` is not updated, so RR fairness among 1..`N_REQ-1` is preserved.
- Macro not defined: pure round-robin over all `N_REQ` requesters.

## Test plan

- Reset mid-grant:
  - Stimulus: requester 2 sends 3 beats (0x0A, 0x0B, 0x0C with last on 0x0C), `out_rdy_i`=1; at cycle 2 of the grant assert `rst` for 1 cycle.
  - Required: IDLE next edge, all outputs 0, `ptr`=0.
- RR fairness:
  - Stimulus: all 4 requesters valid with 1-beat messages (last=1) continuously, `out_rdy_i`=1.
  - Required: grant order 0,1,2,3,0,1…; one beat every 2 cycles; `out_dat_o` equals the respective slice.
- Message atomicity with backpressure:
  - Stimulus: requester 1 sends 5 beats 0x101..0x105 (last on 0x105); requester 3 valid throughout; `out_rdy_i` toggles 1/0 every cycle.
  - Required: all 5 of requester 1's beats appear before any of requester 3's; `req_rdy_o[3]`=0 during that time.
- Burst limit:
  - Stimulus: `MAX_BURST`=16; requester 0 streams 20 beats with no last; requester 1 valid.
  - Required: release after beat 16; requester 1 is granted next; requester 0 is regranted afterwards for beats 17..20.
- `arb_en` drop:
  - Stimulus: deassert `arb_en` during a 4-beat message from requester 2.
  - Required: all 4 beats complete; `grant_o` stays 0 until `arb_en`=1 again.
- With `PRMCU_UART_ARB_PRIO_EN` defined:
  - Stimulus: requesters 0 and 3 continuously valid with 1-beat messages.
  - Required: requester 0 is granted every time; requester 3 is granted only once requester 0 drops valid.
